// File: rtl/posit_mul_pkg.sv
// Shared types, posit constants and the round-robin pick function used by the
// posit multiplier arbiter.
package posit_mul_pkg;

  localparam int unsigned POSIT_N = 32;
  localparam int unsigned MAX_REQ = 8;

  typedef logic [POSIT_N-1:0]         posit_t;
  typedef logic [$clog2(MAX_REQ)-1:0] req_id_t;

  localparam posit_t POSIT_ZERO = '0;
  localparam posit_t POSIT_NAR  = {1'b1, {(POSIT_N-1){1'b0}}};

  // One-hot grant for the first set bit of valid at or after ptr, wrapping at nreq.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input req_id_t            ptr,
                                                 input int unsigned        nreq);
    logic [MAX_REQ-1:0] grant;
    int unsigned        idx;
    req_id_t            sel;
    grant = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = (32'(ptr) + k) % nreq;
      sel = req_id_t'(idx);
      if (k < nreq && grant == '0 && valid[sel]) grant[sel] = 1'b1;
    end
    return grant;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus its index; the pointer moves past the
// winner only when the grant is actually consumed.
module rr_arbiter
  import posit_mul_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_advance,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  logic [IDW-1:0]     r_rr_ptr;
  logic [MAX_REQ-1:0] w_req_ext;
  logic [MAX_REQ-1:0] w_pick;
  logic [IDW-1:0]     w_next_ptr;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_req_ext             = '0;
    w_req_ext[NREQ-1:0]   = i_req;
    w_pick                = rr_pick(w_req_ext, req_id_t'(r_rr_ptr), NREQ);
    o_idx                 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick[i]) o_idx = IDW'(i);
    end
  end

  assign o_grant    = w_pick[NREQ-1:0];
  assign o_any      = |w_pick;
  assign w_next_ptr = (o_idx == IDW'(NREQ - 1)) ? '0 : o_idx + 1'b1;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge
  // values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (i_advance) begin
      r_rr_ptr <= w_next_ptr;
    end
  end

endmodule

// File: rtl/posit_mul_arbiter.sv
// Shares one combinational posit multiplier between NREQ requesters through a
// two-stage (issue, result) pipeline with valid/ready backpressure.
module posit_mul_arbiter
  import posit_mul_pkg::*;
#(
  parameter int N    = 32,
  parameter int ES   = 2,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [N-1:0]      mul_in1,
  output logic [N-1:0]      mul_in2,
  input  logic [N-1:0]      mul_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [N-1:0]      rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy
);

  if (NREQ < 2 || NREQ > MAX_REQ || ES >= N) begin : g_bad_params
    $error("posit_mul_arbiter: unsupported NREQ/ES/N combination");
  end

  logic            r_s1_valid;
  logic [N-1:0]    r_s1_a;
  logic [N-1:0]    r_s1_b;
  logic [IDW-1:0]  r_s1_id;
  logic            r_s2_valid;
  logic [N-1:0]    r_s2_data;
  logic [IDW-1:0]  r_s2_id;

  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_idx;
  logic            w_any;
  logic            w_s1_en;
  logic            w_s2_en;
  logic [N-1:0]    w_a;
  logic [N-1:0]    w_b;

  assign w_s2_en = !r_s2_valid || rsp_ready;
  assign w_s1_en = !r_s1_valid || w_s2_en;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (req_valid),
    .i_advance (w_any && w_s1_en),
    .o_grant   (w_grant),
    .o_idx     (w_idx),
    .o_any     (w_any)
  );

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_a = req_a[i*N +: N];
        w_b = req_b[i*N +: N];
      end
    end
  end

  // NOTE: the operand and result registers are reset as well, because the
  // multiplier inputs and the response payload must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= N'(POSIT_ZERO);
      r_s1_b     <= N'(POSIT_ZERO);
      r_s1_id    <= '0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= N'(POSIT_ZERO);
      r_s2_id    <= '0;
    end else begin
      if (w_s2_en) begin
        r_s2_valid <= r_s1_valid;
        r_s2_data  <= mul_out;
        r_s2_id    <= r_s1_id;
      end
      // Without a grant only the valid bit moves; stale operands stay on the multiplier.
      if (w_s1_en) begin
        r_s1_valid <= w_any;
        if (w_any) begin
          r_s1_a  <= w_a;
          r_s1_b  <= w_b;
          r_s1_id <= w_idx;
        end
      end
    end
  end

  assign req_ready = w_grant & {NREQ{w_s1_en}};
  assign mul_in1   = r_s1_a;
  assign mul_in2   = r_s1_b;
  assign rsp_valid = r_s2_valid;
  assign rsp_data  = r_s2_data;
  assign rsp_id    = r_s2_id;
  assign busy      = r_s1_valid || r_s2_valid;

endmodule

// File: tb/tb_posit_mul_arbiter.sv
// Self-checking bench for posit_mul_arbiter with a stand-in multiplier that is
// exact for the operand patterns used here (zero, NaR, and multiplication by 1.0).
module tb_posit_mul_arbiter;
  import posit_mul_pkg::*;

  localparam int N    = 32;
  localparam int ES   = 2;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  localparam logic [31:0] ONE = 32'h4000_0000;
  localparam logic [31:0] TWO = 32'h4800_0000;
  localparam logic [31:0] NAR = POSIT_NAR;
  localparam logic [31:0] ZRO = POSIT_ZERO;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [N-1:0]      mul_in1;
  logic [N-1:0]      mul_in2;
  logic [N-1:0]      mul_out;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [N-1:0]      rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              busy;

  logic [N-1:0] a_arr   [NREQ];
  logic [N-1:0] b_arr   [NREQ];
  logic [N-1:0] exp_arr [NREQ];

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [N-1:0]   data;
  } rsp_t;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  rsp_t           exp_q[$];
  logic [IDW-1:0] got_ids[$];
  rsp_t           sb_e;
  int             n_cmp = 0;
  int             n_err = 0;

  always #5 clk = ~clk;

  posit_mul_arbiter #(
    .N    (N),
    .ES   (ES),
    .NREQ (NREQ),
    .IDW  (IDW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_in1   (mul_in1),
    .mul_in2   (mul_in2),
    .mul_out   (mul_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  function automatic logic [N-1:0] mul_stub(input logic [N-1:0] a, input logic [N-1:0] b);
    if (a == NAR || b == NAR) return NAR;
    if (a == ZRO || b == ZRO) return ZRO;
    if (a == ONE) return b;
    if (b == ONE) return a;
    return a ^ b;
  endfunction

  assign mul_out = mul_stub(mul_in1, mul_in2);

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = a_arr[i];
      req_b[i*N +: N] = b_arr[i];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: pop on response handshake, push on request handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_rsp", 32'(exp_q.size()), 32'd1);
        end else begin
          sb_e = exp_q.pop_front();
          check("sb_rsp_data", rsp_data, sb_e.data);
          check("sb_rsp_id", 32'(rsp_id), 32'(sb_e.id));
          got_ids.push_back(rsp_id);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) exp_q.push_back({IDW'(i), exp_arr[i]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Present one request alone, wait (bounded) for its accept, then withdraw it.
  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, output int waited);
    a_arr[id]   = a;
    b_arr[id]   = b;
    exp_arr[id] = e;
    req_valid   = 4'(1) << id;
    waited      = 0;
    sample();
    while (!req_ready[id] && waited < 20) begin
      step();
      sample();
      waited++;
    end
    check($sformatf("accept_req%0d", id), 32'(req_ready), 32'(1) << id);
    step();
    req_valid = '0;
  endtask

  vec_t        vecs[6];
  int          waited;
  int          accepts;
  logic [31:0] held;

  initial begin
    vecs[0] = '{0, ONE, TWO, TWO};
    vecs[1] = '{1, NAR, ONE, NAR};
    vecs[2] = '{2, ZRO, TWO, ZRO};
    vecs[3] = '{3, TWO, ONE, TWO};
    vecs[4] = '{1, ONE, NAR, NAR};
    vecs[5] = '{0, NAR, ZRO, NAR};

    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i]   = '0;
      b_arr[i]   = '0;
      exp_arr[i] = '0;
    end

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_mul_in1", mul_in1, 32'd0);
    check("rst_mul_in2", mul_in2, 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    step();

    // Single-request vectors: two-cycle latency and special-value pass-through.
    foreach (vecs[v]) begin
      issue(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].exp, waited);
      sample();
      check($sformatf("vec%0d_early_valid", v), 32'(rsp_valid), 32'd0);
      check($sformatf("vec%0d_busy", v), 32'(busy), 32'd1);
      step();
      sample();
      check($sformatf("vec%0d_rsp_valid", v), 32'(rsp_valid), 32'd1);
      check($sformatf("vec%0d_rsp_data", v), rsp_data, vecs[v].exp);
      check($sformatf("vec%0d_rsp_id", v), 32'(rsp_id), 32'(vecs[v].id));
      step();
    end

    // Sparse/wrapping: pointer is 1 here, a lone requester 3 must win at once.
    issue(3, ONE, 32'h1111_0003, 32'h1111_0003, waited);
    check("lone_req3_wait", 32'(waited), 32'd0);
    repeat (3) step();
    issue(2, ONE, 32'h1111_0002, 32'h1111_0002, waited);
    repeat (3) step();
    a_arr[0] = ONE; b_arr[0] = 32'h1111_0000; exp_arr[0] = 32'h1111_0000;
    a_arr[2] = ONE; b_arr[2] = 32'h1111_0022; exp_arr[2] = 32'h1111_0022;
    req_valid = 4'b0101;
    sample();
    check("wrap_grant0", 32'(req_ready), 32'b0001);
    step();
    sample();
    check("wrap_grant2", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    repeat (3) step();
    issue(3, ONE, 32'h1111_0033, 32'h1111_0033, waited);
    repeat (3) step();

    // Fairness: all requesters held, pointer at 0, one product per cycle.
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i]   = ONE;
      b_arr[i]   = 32'h2000_0000 | 32'(i);
      exp_arr[i] = 32'h2000_0000 | 32'(i);
    end
    req_valid = '1;
    for (int k = 0; k < 10; k++) begin
      if (k == 8) req_valid = '0;
      sample();
      if (k < 8) check($sformatf("fair_grant_c%0d", k), 32'(req_ready), 32'(1) << (k % 4));
      if (k >= 2) begin
        check($sformatf("fair_valid_c%0d", k), 32'(rsp_valid), 32'd1);
        check($sformatf("fair_id_c%0d", k), 32'(rsp_id), 32'((k - 2) % 4));
        check($sformatf("fair_data_c%0d", k), rsp_data, 32'h2000_0000 | 32'((k - 2) % 4));
      end
      step();
    end

    // Backpressure: consumer stalled, exactly two accepts fill the pipeline.
    for (int i = 0; i < NREQ; i++) begin
      b_arr[i]   = 32'h3000_0000 | 32'(i);
      exp_arr[i] = 32'h3000_0000 | 32'(i);
    end
    got_ids.delete();
    rsp_ready = 1'b0;
    req_valid = '1;
    accepts   = 0;
    held      = '0;
    for (int k = 0; k < 5; k++) begin
      sample();
      if (req_ready != '0) accepts++;
      if (k == 2) held = rsp_data;
      step();
    end
    sample();
    check("bp_accepts", 32'(accepts), 32'd2);
    check("bp_req_ready", 32'(req_ready), 32'd0);
    check("bp_data_stable", rsp_data, held);
    check("bp_data", rsp_data, 32'h3000_0000);
    step();
    rsp_ready = 1'b1;
    req_valid = '0;
    repeat (3) step();
    check("bp_rsp_count", 32'(got_ids.size()), 32'd2);
    if (got_ids.size() == 2) begin
      check("bp_order0", 32'(got_ids[0]), 32'd0);
      check("bp_order1", 32'(got_ids[1]), 32'd1);
    end

    // Reset with both stages full: outputs drop without a clock edge.
    for (int i = 0; i < NREQ; i++) begin
      b_arr[i]   = 32'h5000_0000 | 32'(i);
      exp_arr[i] = 32'h5000_0000 | 32'(i);
    end
    rsp_ready = 1'b0;
    req_valid = '1;
    repeat (2) begin
      sample();
      step();
    end
    sample();
    check("prerst_busy", 32'(busy), 32'd1);
    check("prerst_rsp_valid", 32'(rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    req_valid = '0;
    step();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sample();
      check($sformatf("postrst_no_rsp_c%0d", k), 32'(rsp_valid), 32'd0);
      step();
    end
    req_valid = '1;
    sample();
    check("postrst_ptr0", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    repeat (4) step();
    sample();
    check("final_busy", 32'(busy), 32'd0);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

endmodule
